// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller.
// Holds the 3-bit op encodings, the 2-bit controller state encodings and
// small op-classification helpers used by the controller and its bench.
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_RUN  = 2'd2,
        ST_DONE     = 2'd3
    } md_state_e;

    function automatic logic is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Bundle of the EX-side request signals and the external multiplier /
// divider handshake seen by muldiv_ctrl.
//   slave  : the controller (consumes EX request + unit results)
//   master : the surrounding pipeline and arithmetic units
interface muldiv_ctrl_if #(
    parameter int WIDTH = 32
) ();
    import muldiv_ctrl_pkg::*;

    logic                 op_valid_i;
    logic [2:0]           op_i;
    logic [WIDTH-1:0]     src_a_i;
    logic [WIDTH-1:0]     src_b_i;
    logic                 hold_i;
    logic                 flush_i;
    logic                 stall_o;
    logic [WIDTH-1:0]     hi_o;
    logic [WIDTH-1:0]     lo_o;
    logic                 mul_sign_o;
    logic [2*WIDTH-1:0]   mul_result_i;
    logic                 div_start_o;
    logic                 div_sign_o;
    logic                 div_cancel_o;
    logic                 div_ready_i;
    logic [2*WIDTH-1:0]   div_result_i;

    modport slave (
        input  op_valid_i, op_i, src_a_i, src_b_i, hold_i, flush_i,
        input  mul_result_i, div_ready_i, div_result_i,
        output stall_o, hi_o, lo_o, mul_sign_o,
        output div_start_o, div_sign_o, div_cancel_o
    );

    modport master (
        output op_valid_i, op_i, src_a_i, src_b_i, hold_i, flush_i,
        output mul_result_i, div_ready_i, div_result_i,
        input  stall_o, hi_o, lo_o, mul_sign_o,
        input  div_start_o, div_sign_o, div_cancel_o
    );

endinterface

// File: rtl/muldiv_ctrl_hilo.sv
// Architectural HI/LO register pair.
// Ports: clk, rst (sync, active-high, clears both), we_hi / we_lo with a
// shared single-word write data, we_pair with a {hi,lo} double-word write
// data (takes priority), hi / lo outputs.
module muldiv_ctrl_hilo #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we_hi,
    input  logic               we_lo,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               we_pair,
    input  logic [2*WIDTH-1:0] pair_wdata,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (we_pair) begin
            hi <= pair_wdata[2*WIDTH-1:WIDTH];
            lo <= pair_wdata[WIDTH-1:0];
        end else begin
            if (we_hi) hi <= wdata;
            if (we_lo) lo <= wdata;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: drives the external MUL_LAT-stage
// multiplier and iterative divider, stalls EX until a result exists, owns
// HI/LO and writes them only on the edge the EX instruction advances.
// Ports: clk, rst (sync, active-high); bus (muldiv_ctrl_if.slave) carrying
// the EX request, hold/flush, stall, HI/LO and the unit handshakes.
// Build option: MULDIV_DIV0_BYPASS_EN -- a divide by zero skips the divider
// and completes with {HI,LO} = {dividend, all ones} after one stall cycle.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int WIDTH   = 32
) (
    input logic          clk,
    input logic          rst,
    muldiv_ctrl_if.slave bus
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    md_state_e            state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [2*WIDTH-1:0]   res_q, res_nx;
    logic                 advance;
    logic                 we_hi, we_lo, we_pair;
    logic [2*WIDTH-1:0]   pair_wdata;
    logic [WIDTH-1:0]     hi, lo;

    assign advance        = !bus.hold_i && !bus.flush_i;
    assign bus.mul_sign_o = (bus.op_i == MD_MULT);
    assign bus.div_sign_o = (bus.op_i == MD_DIV);
    assign bus.hi_o       = hi;
    assign bus.lo_o       = lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            res_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            res_q <= res_nx;
        end
    end

    // stall_o depends only on state, op_valid_i and op_i so it never forms a
    // combinational path from the divider's ready pulse or from hold/flush.
    always_comb begin
        state_nx         = state;
        cnt_nx           = cnt;
        res_nx           = res_q;
        bus.stall_o      = 1'b0;
        bus.div_start_o  = 1'b0;
        bus.div_cancel_o = 1'b0;
        we_hi            = 1'b0;
        we_lo            = 1'b0;
        we_pair          = 1'b0;
        pair_wdata       = res_q;

        case (state)
            ST_IDLE: begin
                if (bus.op_valid_i) begin
                    if (is_mul(bus.op_i)) begin
                        if (MUL_LAT == 0) begin
                            pair_wdata = bus.mul_result_i;
                            we_pair    = advance;
                        end else begin
                            bus.stall_o = 1'b1;
                            if (!bus.flush_i) begin
                                state_nx = ST_MUL_WAIT;
                                cnt_nx   = CNT_W'(MUL_LAT - 1);
                            end
                        end
                    end else if (is_div(bus.op_i)) begin
                        bus.stall_o = 1'b1;
                        if (!bus.flush_i) begin
`ifdef MULDIV_DIV0_BYPASS_EN
                            if (bus.src_b_i == '0) begin
                                res_nx   = {bus.src_a_i, {WIDTH{1'b1}}};
                                state_nx = ST_DONE;
                            end else begin
                                bus.div_start_o = 1'b1;
                                state_nx        = ST_DIV_RUN;
                            end
`else
                            bus.div_start_o = 1'b1;
                            state_nx        = ST_DIV_RUN;
`endif
                        end
                    end else if (bus.op_i == MD_MTHI) begin
                        we_hi = advance;
                    end else if (bus.op_i == MD_MTLO) begin
                        we_lo = advance;
                    end
                end
            end

            ST_MUL_WAIT: begin
                bus.stall_o = 1'b1;
                if (bus.flush_i) begin
                    state_nx = ST_IDLE;
                end else if (cnt == '0) begin
                    res_nx   = bus.mul_result_i;
                    state_nx = ST_DONE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end

            ST_DIV_RUN: begin
                bus.stall_o = 1'b1;
                if (bus.flush_i) begin
                    // A divider that is finishing this cycle stops by itself.
                    bus.div_cancel_o = !bus.div_ready_i;
                    state_nx         = ST_IDLE;
                end else if (bus.div_ready_i) begin
                    res_nx   = bus.div_result_i;
                    state_nx = ST_DONE;
                end
            end

            ST_DONE: begin
                // The op still on the inputs is the finished one; never re-issue it.
                if (bus.flush_i) begin
                    state_nx = ST_IDLE;
                end else if (!bus.hold_i) begin
                    we_pair  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end

            default: state_nx = ST_IDLE;
        endcase
    end

    muldiv_ctrl_hilo #(.WIDTH(WIDTH)) u_hilo (
        .clk        (clk),
        .rst        (rst),
        .we_hi      (we_hi),
        .we_lo      (we_lo),
        .wdata      (bus.src_a_i),
        .we_pair    (we_pair),
        .pair_wdata (pair_wdata),
        .hi         (hi),
        .lo         (lo)
    );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with MUL_LAT=2 and a 33-cycle divider model.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int MUL_LAT = 2;
    localparam int WIDTH   = 32;
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_start  = 0;

    muldiv_ctrl_if #(.WIDTH(WIDTH)) bus ();

    muldiv_ctrl #(.MUL_LAT(MUL_LAT), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Multiplier model: MUL_LAT register stages after the operands.
    function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn);
        logic [63:0] ea, eb;
        ea = {{32{sgn & a[31]}}, a};
        eb = {{32{sgn & b[31]}}, b};
        return ea * eb;
    endfunction

    logic [63:0] mp0, mp1;
    always @(posedge clk) begin
        mp0 <= mul_model(bus.src_a_i, bus.src_b_i, bus.mul_sign_o);
        mp1 <= mp0;
    end
    assign bus.mul_result_i = mp1;

    // Divider model: ready pulse DIV_LAT cycles after the start cycle.
    function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn);
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sa = a;
        sb = b;
        if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    logic        dv_busy;
    int          dv_cnt;
    logic [31:0] dv_a, dv_b;
    logic        dv_sign;
    always @(posedge clk) begin
        if (rst) begin
            dv_busy <= 1'b0;
            dv_cnt  <= 0;
        end else if (bus.div_cancel_o) begin
            dv_busy <= 1'b0;
        end else if (bus.div_start_o) begin
            dv_busy <= 1'b1;
            dv_cnt  <= 1;
            dv_a    <= bus.src_a_i;
            dv_b    <= bus.src_b_i;
            dv_sign <= bus.div_sign_o;
            n_start <= n_start + 1;
        end else if (dv_busy) begin
            if (dv_cnt == DIV_LAT) dv_busy <= 1'b0;
            else dv_cnt <= dv_cnt + 1;
        end
    end
    assign bus.div_ready_i  = dv_busy && (dv_cnt == DIV_LAT);
    assign bus.div_result_i = div_model(dv_a, dv_b, dv_sign);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op and count stall cycles until the controller stops stalling.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int sc);
        bus.op_valid_i = 1'b1;
        bus.op_i       = op;
        bus.src_a_i    = a;
        bus.src_b_i    = b;
        sc             = 0;
        #1;
        while (bus.stall_o && sc < 100) begin
            sc++;
            step();
        end
    endtask

    // Advance through the commit edge and retire the op.
    task automatic commit();
        step();
        bus.op_valid_i = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int st0;
        logic [31:0] exp_hi, exp_lo;

        rst            = 1'b1;
        bus.op_valid_i = 1'b0;
        bus.op_i       = MD_MTHI;
        bus.src_a_i    = '0;
        bus.src_b_i    = '0;
        bus.hold_i     = 1'b0;
        bus.flush_i    = 1'b0;
        step();
        step();
        chk("rst_hi", bus.hi_o, 0);
        chk("rst_lo", bus.lo_o, 0);
        chk("rst_stall", bus.stall_o, 0);
        chk("rst_start", bus.div_start_o, 0);
        chk("rst_cancel", bus.div_cancel_o, 0);
        rst = 1'b0;
        step();

        // MULT -2 * 3: issue cycle plus MUL_LAT wait cycles of stall.
        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, sc);
        chk("mult_stall_cycles", sc, 3);
        commit();
        chk("mult_hi", bus.hi_o, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo_o, 32'hFFFF_FFFA);

        // MULTU 0xFFFFFFFE * 3 = 0x2_FFFFFFFA
        issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3, sc);
        commit();
        chk("multu_hi", bus.hi_o, 32'h2);
        chk("multu_lo", bus.lo_o, 32'hFFFF_FFFA);

        // DIVU 100 / 7: issue cycle + 33 divider cycles of stall.
        st0 = n_start;
        issue(MD_DIVU, 32'd100, 32'd7, sc);
        chk("divu_stall_cycles", sc, 34);
        commit();
        chk("divu_starts", n_start - st0, 1);
        chk("divu_hi", bus.hi_o, 32'd2);
        chk("divu_lo", bus.lo_o, 32'd14);

        // DIV -7 / 2 = -3 rem -1
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, sc);
        commit();
        chk("div_hi", bus.hi_o, 32'hFFFF_FFFF);
        chk("div_lo", bus.lo_o, 32'hFFFF_FFFD);
        exp_hi = 32'hFFFF_FFFF;
        exp_lo = 32'hFFFF_FFFD;

        // DIV flushed in its 5th DIV_RUN cycle.
        st0            = n_start;
        bus.op_valid_i = 1'b1;
        bus.op_i       = MD_DIV;
        bus.src_a_i    = 32'hFFFF_FFF9;
        bus.src_b_i    = 32'd2;
        #1;
        chk("flush_div_start", bus.div_start_o, 1);
        repeat (5) step();
        bus.flush_i = 1'b1;
        #1;
        chk("flush_cancel", bus.div_cancel_o, 1);
        chk("flush_stall", bus.stall_o, 1);
        step();
        bus.flush_i    = 1'b0;
        bus.op_valid_i = 1'b0;
        #1;
        chk("flush_idle_stall", bus.stall_o, 0);
        chk("flush_idle_cancel", bus.div_cancel_o, 0);
        repeat (40) step();
        chk("flush_hi", bus.hi_o, exp_hi);
        chk("flush_lo", bus.lo_o, exp_lo);
        chk("flush_starts", n_start - st0, 1);

        // Flush in the same cycle as the divider's ready pulse.
        bus.op_valid_i = 1'b1;
        bus.op_i       = MD_DIVU;
        bus.src_a_i    = 32'd200;
        bus.src_b_i    = 32'd3;
        #1;
        step();
        repeat (32) step();
        bus.flush_i = 1'b1;
        #1;
        chk("rdyflush_cancel", bus.div_cancel_o, 0);
        chk("rdyflush_stall", bus.stall_o, 1);
        step();
        bus.flush_i    = 1'b0;
        bus.op_valid_i = 1'b0;
        #1;
        chk("rdyflush_idle_stall", bus.stall_o, 0);
        repeat (3) step();
        chk("rdyflush_hi", bus.hi_o, exp_hi);
        chk("rdyflush_lo", bus.lo_o, exp_lo);

        // DONE held for 3 cycles: single commit, no re-issue. 30/4 = 7 rem 2.
        st0 = n_start;
        issue(MD_DIVU, 32'd30, 32'd4, sc);
        chk("hold_stall_cycles", sc, 34);
        bus.hold_i = 1'b1;
        #1;
        chk("hold_done_stall", bus.stall_o, 0);
        repeat (3) step();
        chk("hold_lo_unwritten", bus.lo_o, exp_lo);
        chk("hold_start_none", bus.div_start_o, 0);
        bus.hold_i = 1'b0;
        commit();
        chk("hold_hi", bus.hi_o, 32'd2);
        chk("hold_lo", bus.lo_o, 32'd7);
        repeat (5) step();
        chk("hold_starts", n_start - st0, 1);
        chk("hold_stall_after", bus.stall_o, 0);

        // MTHI flushed, then MTLO.
        bus.op_valid_i = 1'b1;
        bus.op_i       = MD_MTHI;
        bus.src_a_i    = 32'h1234;
        bus.flush_i    = 1'b1;
        #1;
        chk("mthi_stall", bus.stall_o, 0);
        step();
        bus.flush_i    = 1'b0;
        bus.op_valid_i = 1'b0;
        #1;
        chk("mthi_flush_hi", bus.hi_o, 32'd2);
        issue(MD_MTLO, 32'h55, 32'd0, sc);
        chk("mtlo_stall_cycles", sc, 0);
        commit();
        chk("mtlo_lo", bus.lo_o, 32'h55);
        chk("mtlo_hi", bus.hi_o, 32'd2);

        // DIVU by zero.
        st0 = n_start;
        issue(MD_DIVU, 32'h0000_ABCD, 32'd0, sc);
        commit();
`ifdef MULDIV_DIV0_BYPASS_EN
        chk("div0_stall_cycles", sc, 1);
        chk("div0_starts", n_start - st0, 0);
`else
        chk("div0_stall_cycles", sc, 34);
        chk("div0_starts", n_start - st0, 1);
`endif
        chk("div0_hi", bus.hi_o, 32'h0000_ABCD);
        chk("div0_lo", bus.lo_o, 32'hFFFF_FFFF);

        // Reset in the middle of a multiply.
        bus.op_valid_i = 1'b1;
        bus.op_i       = MD_MULT;
        bus.src_a_i    = 32'd7;
        bus.src_b_i    = 32'd9;
        #1;
        step();
        rst = 1'b1;
        step();
        rst            = 1'b0;
        bus.op_valid_i = 1'b0;
        #1;
        chk("midrst_stall", bus.stall_o, 0);
        chk("midrst_hi", bus.hi_o, 0);
        chk("midrst_lo", bus.lo_o, 0);
        repeat (4) step();
        chk("midrst_lo_after", bus.lo_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
